// File: rtl/count_monitor.sv
// count_monitor
//   Watches the output of an upstream synchronous counter and reports the
//   following events, each one clock after the edge that samples it:
//   - wrap_pulse: the counter stepped from all-ones to zero.
//   - match_pulse: the counter stepped into the compare value.
//   - wrap_cnt: a saturating count of those wraps.
//   It can also flag illegal steps (see configuration below).
//
// Parameters
//   WIDTH   width of the monitored count bus (default 3)
//   WRAP_W  width of the saturating wrap counter (default 8)
//
// Ports
//   clk          single clock; all state changes happen on its rising edge
//   rst          asynchronous, active-low reset
//   q_in         count value from the upstream counter, sampled every edge
//   match        compare value for match detection
//   clr          synchronous clear of all status; returns the FSM to IDLE
//   wrap_pulse   one-cycle pulse after a wrap step
//   match_pulse  one-cycle pulse after a step into match
//   wrap_cnt     saturating number of wraps since reset or clr
//   seq_err      sticky illegal-step flag
//   err_val      q_in value captured at the first illegal step
//
// Configuration
//   COUNT_MONITOR_SEQ_CHECK_EN
//     When defined, only +1 steps (modulo 2^WIDTH) and holds are legal.
//     Any other step sets seq_err, captures err_val and parks the FSM in
//     ERR until clr.
//     When undefined, every non-hold value is accepted. seq_err and
//     err_val are tied to zero, and ERR can never be reached.

module count_monitor #(
  parameter int WIDTH  = 3,
  parameter int WRAP_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [WIDTH-1:0]  q_in,
  input  logic [WIDTH-1:0]  match,
  input  logic              clr,
  output logic              wrap_pulse,
  output logic              match_pulse,
  output logic [WRAP_W-1:0] wrap_cnt,
  output logic              seq_err,
  output logic [WIDTH-1:0]  err_val
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    TRACK = 2'd1,
    ERR   = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [WIDTH-1:0]  prev_q, prev_d;
  logic              wrap_pulse_q, wrap_pulse_d;
  logic              match_pulse_q, match_pulse_d;
  logic [WRAP_W-1:0] wrap_cnt_q, wrap_cnt_d;

  logic is_hold;
  logic is_wrap;
  logic accept;

`ifdef COUNT_MONITOR_SEQ_CHECK_EN
  logic              seq_err_q, seq_err_d;
  logic [WIDTH-1:0]  err_val_q, err_val_d;
  logic [WIDTH-1:0]  prev_inc;

  assign prev_inc = prev_q + WIDTH'(1);
  assign accept   = (q_in == prev_inc);
`else
  // Without sequence checking, any change of value counts as a step.
  assign accept   = ~is_hold;
`endif

  assign is_hold = (q_in == prev_q);
  assign is_wrap = (prev_q == '1) && (q_in == '0);

  // Next-state and status computation. clr is applied last so that it
  // overrides any wrap, match or error sampled on the same edge.
  always_comb begin
    state_d       = state_q;
    prev_d        = prev_q;
    wrap_pulse_d  = 1'b0;
    match_pulse_d = 1'b0;
    wrap_cnt_d    = wrap_cnt_q;
`ifdef COUNT_MONITOR_SEQ_CHECK_EN
    seq_err_d     = seq_err_q;
    err_val_d     = err_val_q;
`endif

    case (state_q)
      IDLE: begin
        prev_d  = q_in;
        state_d = TRACK;
      end
      TRACK: begin
        if (accept) begin
          prev_d        = q_in;
          wrap_pulse_d  = is_wrap;
          match_pulse_d = (q_in == match);
          if (is_wrap && (wrap_cnt_q != '1)) begin
            wrap_cnt_d = wrap_cnt_q + WRAP_W'(1);
          end
        end
`ifdef COUNT_MONITOR_SEQ_CHECK_EN
        else if (!is_hold) begin
          seq_err_d = 1'b1;
          err_val_d = q_in;
          state_d   = ERR;
        end
`endif
      end
      // ERR freezes everything until clr.
      ERR: ;
      default: state_d = IDLE;
    endcase

    if (clr) begin
      state_d       = IDLE;
      wrap_pulse_d  = 1'b0;
      match_pulse_d = 1'b0;
      wrap_cnt_d    = '0;
`ifdef COUNT_MONITOR_SEQ_CHECK_EN
      seq_err_d     = 1'b0;
      err_val_d     = '0;
`endif
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= IDLE;
      prev_q        <= '0;
      wrap_pulse_q  <= 1'b0;
      match_pulse_q <= 1'b0;
      wrap_cnt_q    <= '0;
    end else begin
      state_q       <= state_d;
      prev_q        <= prev_d;
      wrap_pulse_q  <= wrap_pulse_d;
      match_pulse_q <= match_pulse_d;
      wrap_cnt_q    <= wrap_cnt_d;
    end
  end

`ifdef COUNT_MONITOR_SEQ_CHECK_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      seq_err_q <= 1'b0;
      err_val_q <= '0;
    end else begin
      seq_err_q <= seq_err_d;
      err_val_q <= err_val_d;
    end
  end

  assign seq_err = seq_err_q;
  assign err_val = err_val_q;
`else
  assign seq_err = 1'b0;
  assign err_val = '0;
`endif

  assign wrap_pulse  = wrap_pulse_q;
  assign match_pulse = match_pulse_q;
  assign wrap_cnt    = wrap_cnt_q;

endmodule

// File: tb/tb_count_monitor.sv
// tb_count_monitor
//   Directed bench for count_monitor with WIDTH = 3. A second instance with
//   WRAP_W = 2 shares the same inputs so that saturation can be observed.
//   Expectations that depend on COUNT_MONITOR_SEQ_CHECK_EN follow the same
//   macro.

module tb_count_monitor;

  logic       clk;
  logic       rst;
  logic [2:0] q_in;
  logic [2:0] match;
  logic       clr;

  logic       wrap_pulse, match_pulse, seq_err;
  logic [7:0] wrap_cnt;
  logic [2:0] err_val;

  logic       wrap_pulse2, match_pulse2, seq_err2;
  logic [1:0] wrap_cnt2;
  logic [2:0] err_val2;

  int assert_count = 0;
  int fail_count   = 0;

  int exp_cnt;
  logic exp_wrap, exp_match;

  count_monitor #(.WIDTH(3), .WRAP_W(8)) dut (
    .clk(clk), .rst(rst), .q_in(q_in), .match(match), .clr(clr),
    .wrap_pulse(wrap_pulse), .match_pulse(match_pulse),
    .wrap_cnt(wrap_cnt), .seq_err(seq_err), .err_val(err_val)
  );

  count_monitor #(.WIDTH(3), .WRAP_W(2)) dut_sat (
    .clk(clk), .rst(rst), .q_in(q_in), .match(match), .clr(clr),
    .wrap_pulse(wrap_pulse2), .match_pulse(match_pulse2),
    .wrap_cnt(wrap_cnt2), .seq_err(seq_err2), .err_val(err_val2)
  );

  // Free-running clock: rising edges at 5, 15, 25, ...
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Watchdog so that the run always ends.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected $finish");
    $fatal(1, "[TB] watchdog expired");
  end

  // Drive one set of inputs, let one rising edge sample them, then return
  // 1 time unit later so that the registered outputs can be checked.
  task automatic applyStimulus(input logic [2:0] q, input logic [2:0] m, input logic c);
    q_in  = q;
    match = m;
    clr   = c;
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    assert_count++;
    if (actual !== expected) begin
      fail_count++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, actual, expected);
    end
  endtask

  initial begin
    rst   = 1'b0;
    q_in  = 3'd0;
    match = 3'd5;
    clr   = 1'b0;

    // Reset state
    #12;
    checkOutput("reset wrap_pulse", 32'(wrap_pulse), 0);
    checkOutput("reset match_pulse", 32'(match_pulse), 0);
    checkOutput("reset wrap_cnt", 32'(wrap_cnt), 0);
    checkOutput("reset seq_err", 32'(seq_err), 0);
    checkOutput("reset err_val", 32'(err_val), 0);
    rst = 1'b1;
    #1;

    // Free-running 0..7 for 20 cycles with match = 5.
    // The first sample only loads prev.
    exp_cnt = 0;
    for (int i = 0; i < 20; i++) begin
      applyStimulus(3'(i % 8), 3'd5, 1'b0);
      exp_wrap  = (i > 0) && (i % 8 == 0);
      exp_match = (i % 8 == 5);
      if (exp_wrap) exp_cnt++;
      checkOutput($sformatf("run wrap_pulse i=%0d", i), 32'(wrap_pulse), 32'(exp_wrap));
      checkOutput($sformatf("run match_pulse i=%0d", i), 32'(match_pulse), 32'(exp_match));
    end
    checkOutput("run wrap_cnt", 32'(wrap_cnt), 2);
    checkOutput("run model cnt", 32'(wrap_cnt), 32'(exp_cnt));
    checkOutput("run seq_err", 32'(seq_err), 0);

    // Step into match, then hold: no re-pulse
    applyStimulus(3'd4, 3'd5, 1'b0);
    checkOutput("hold pre match", 32'(match_pulse), 0);
    applyStimulus(3'd5, 3'd5, 1'b0);
    checkOutput("hold step into match", 32'(match_pulse), 1);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(3'd5, 3'd5, 1'b0);
      checkOutput($sformatf("hold at match %0d", i), 32'(match_pulse), 0);
      checkOutput($sformatf("hold wrap %0d", i), 32'(wrap_pulse), 0);
    end

    // Illegal step 2, 3, 6, then 7 -> 0
    applyStimulus(3'd0, 3'd5, 1'b1);
    checkOutput("clr wrap_cnt", 32'(wrap_cnt), 0);
    applyStimulus(3'd2, 3'd5, 1'b0);
    applyStimulus(3'd3, 3'd5, 1'b0);
    applyStimulus(3'd6, 3'd5, 1'b0);
`ifdef COUNT_MONITOR_SEQ_CHECK_EN
    checkOutput("illegal seq_err", 32'(seq_err), 1);
    checkOutput("illegal err_val", 32'(err_val), 6);
`else
    checkOutput("illegal seq_err", 32'(seq_err), 0);
    checkOutput("illegal err_val", 32'(err_val), 0);
`endif
    applyStimulus(3'd7, 3'd5, 1'b0);
    applyStimulus(3'd0, 3'd5, 1'b0);
`ifdef COUNT_MONITOR_SEQ_CHECK_EN
    checkOutput("err frozen wrap_pulse", 32'(wrap_pulse), 0);
    checkOutput("err frozen wrap_cnt", 32'(wrap_cnt), 0);
    checkOutput("err frozen err_val", 32'(err_val), 6);
`else
    checkOutput("accept wrap_pulse", 32'(wrap_pulse), 1);
    checkOutput("accept wrap_cnt", 32'(wrap_cnt), 1);
    checkOutput("accept seq_err", 32'(seq_err), 0);
`endif

    // clr on the same edge as a 7 -> 0 step
    applyStimulus(3'd0, 3'd5, 1'b1);
    checkOutput("clr seq_err", 32'(seq_err), 0);
    checkOutput("clr err_val", 32'(err_val), 0);
    applyStimulus(3'd6, 3'd5, 1'b0);
    applyStimulus(3'd7, 3'd5, 1'b0);
    applyStimulus(3'd0, 3'd5, 1'b0);
    checkOutput("pre-clr wrap_pulse", 32'(wrap_pulse), 1);
    checkOutput("pre-clr wrap_cnt", 32'(wrap_cnt), 1);
    for (int v = 1; v < 8; v++) applyStimulus(3'(v), 3'd5, 1'b0);
    applyStimulus(3'd0, 3'd5, 1'b1);
    checkOutput("clr-vs-wrap wrap_pulse", 32'(wrap_pulse), 0);
    checkOutput("clr-vs-wrap wrap_cnt", 32'(wrap_cnt), 0);
    checkOutput("clr-vs-wrap match_pulse", 32'(match_pulse), 0);
    applyStimulus(3'd3, 3'd5, 1'b0);
    checkOutput("reload no pulse", 32'(match_pulse | wrap_pulse), 0);
    applyStimulus(3'd4, 3'd5, 1'b0);
    checkOutput("reload legal seq_err", 32'(seq_err), 0);
    applyStimulus(3'd5, 3'd5, 1'b0);
    checkOutput("reload match_pulse", 32'(match_pulse), 1);

    // Five wraps: 8-bit counter reaches 5, 2-bit counter saturates at 3
    applyStimulus(3'd0, 3'd5, 1'b1);
    for (int i = 0; i <= 40; i++) applyStimulus(3'(i % 8), 3'd5, 1'b0);
    checkOutput("sat wide wrap_cnt", 32'(wrap_cnt), 5);
    checkOutput("sat narrow wrap_cnt", 32'(wrap_cnt2), 3);
    checkOutput("sat narrow wrap_pulse", 32'(wrap_pulse2), 1);

    // Asynchronous reset between edges while outputs are non-zero
    #2;
    rst = 1'b0;
    #1;
    checkOutput("async wrap_pulse", 32'(wrap_pulse), 0);
    checkOutput("async wrap_cnt", 32'(wrap_cnt), 0);
    checkOutput("async narrow wrap_cnt", 32'(wrap_cnt2), 0);
    checkOutput("async match_pulse", 32'(match_pulse), 0);
    checkOutput("async seq_err", 32'(seq_err), 0);
    #2;
    rst = 1'b1;
    applyStimulus(3'd5, 3'd5, 1'b0);
    checkOutput("post-reset first match", 32'(match_pulse), 0);
    checkOutput("post-reset first wrap", 32'(wrap_pulse), 0);
    applyStimulus(3'd6, 3'd5, 1'b0);
    applyStimulus(3'd7, 3'd5, 1'b0);
    applyStimulus(3'd0, 3'd5, 1'b0);
    checkOutput("post-reset wrap_pulse", 32'(wrap_pulse), 1);
    checkOutput("post-reset wrap_cnt", 32'(wrap_cnt), 1);

    $display("End of test - %0d assertions evaluated, %0d failures", assert_count, fail_count);
    $finish;
  end

endmodule

// File: doc/count_monitor.md
COUNT_MONITOR -- requirements
Module: count_monitor

Interface
REQ-001 SHALL have parameter WIDTH, default 3: width of the monitored count bus.
REQ-002 SHALL have parameter WRAP_W, default 8: width of the wrap counter.
REQ-003 SHALL have port clk  input  1  the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port q_in  input  WIDTH  count value from the upstream synchronous counter, sampled each rising edge.
REQ-006 SHALL have port match  input  WIDTH  compare value for match detection.
REQ-007 SHALL have port clr  input  1  synchronous clear of status and return to IDLE.
REQ-008 SHALL have port wrap_pulse  output  1  one-cycle pulse on a legal all-ones to zero step.
REQ-009 SHALL have port match_pulse  output  1  one-cycle pulse on a legal step into value match.
REQ-010 SHALL have port wrap_cnt  output  WRAP_W  saturating count of wraps since reset or clr.
REQ-011 SHALL have port seq_err  output  1  sticky illegal-step flag.
REQ-012 SHALL have port err_val  output  WIDTH  q_in value captured at the first illegal step.

Function
REQ-013 SHALL implement an FSM with states IDLE, TRACK, and ERR, plus an internal register prev of WIDTH bits.
REQ-014 In IDLE, the next rising edge SHALL load prev from q_in and move to TRACK, with no pulses.
REQ-015 In TRACK, a legal step SHALL be q_in == prev + 1 modulo 2^WIDTH; on a legal step prev SHALL load q_in.
REQ-016 In TRACK, a hold SHALL be q_in == prev; a hold SHALL be legal, SHALL leave prev unchanged, and SHALL produce no pulses.
REQ-017 wrap_pulse SHALL be registered and high for exactly the one cycle following the edge that samples a legal step from prev = all-ones to q_in = 0.
REQ-018 match_pulse SHALL be registered and high for exactly the one cycle following the edge that samples a legal step with q_in == match; a hold at match SHALL NOT re-pulse.
REQ-019 wrap_pulse and match_pulse SHALL both assert in the same cycle when match = 0 and a wrap occurs.
REQ-020 wrap_cnt SHALL increment on each wrap_pulse event and SHALL saturate at 2^WRAP_W - 1 without rolling over.
REQ-021 In TRACK, any step that is neither legal nor a hold SHALL set seq_err, capture q_in into err_val, and move to ERR.
REQ-022 In ERR, wrap_pulse and match_pulse SHALL stay low, and wrap_cnt, err_val and prev SHALL be frozen until clr.
REQ-023 clr high at an edge SHALL, in any state, clear seq_err, err_val, wrap_cnt and both pulses to 0, and move to IDLE.
REQ-024 clr SHALL take priority over a wrap, match or error sampled at the same edge.
REQ-025 Output latency SHALL be exactly one clock from the sampling edge to the output.

Reset
REQ-026 While rst = 0, the FSM SHALL be held in IDLE and prev, wrap_pulse, match_pulse, wrap_cnt, seq_err and err_val SHALL be forced to 0 immediately, independent of clk.
REQ-027 Reset asserted mid-operation SHALL discard all history.
REQ-028 After rst rises, the first edge SHALL behave as IDLE.

Configuration
REQ-029 With macro COUNT_MONITOR_SEQ_CHECK_EN defined, sequence checking SHALL operate as in REQ-021 and REQ-022.
REQ-030 With COUNT_MONITOR_SEQ_CHECK_EN undefined:
- any non-hold value SHALL be accepted: prev loads q_in.
- wrap SHALL be detected only on an all-ones to 0 step.
- match SHALL be detected on any change into match.
- seq_err and err_val SHALL be tied to 0, and ERR SHALL be unreachable.

Verification
REQ-031 Reset then free-running counter 0..7 for 20 cycles (WIDTH = 3) -> wrap_pulse once per 8 cycles, wrap_cnt = 2 after the second 7->0 step, seq_err = 0.
REQ-032 match = 5, counter running -> match_pulse high the cycle after each 4->5 sample, low otherwise; holding q_in = 5 for 3 cycles -> no further pulses.
REQ-033 Sequence 2, 3, 6 with the macro defined -> seq_err = 1 and err_val = 6 one cycle later; later 7->0 steps give no wrap_pulse. Without the macro -> seq_err stays 0.
REQ-034 clr asserted on the same edge as a sampled 7->0 step -> wrap_pulse stays 0, wrap_cnt = 0, FSM in IDLE; the next edge reloads prev.
REQ-035 WRAP_W = 2 and 5 wraps -> wrap_cnt stops at 3.
REQ-036 rst driven low mid-count between clock edges -> all outputs 0 immediately; after release, the first sample produces no pulse.
